// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU. It produces {remainder, quotient} for the HI/LO path.
// Signed operands are reduced to magnitudes, divided unsigned, and the signs are corrected on completion.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ZERO, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   res_q, res_d;

    logic [WIDTH:0]       shl;
    logic                 borrow;
    logic [WIDTH-1:0]     sub;
    logic                 take;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quo_nx;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic                     sgn);
        if (sgn && (v < 0))
            return $unsigned(-v);
        return $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // When the shifted-out bit is set the partial remainder exceeds any divisor, so the low
    // WIDTH-bit difference is already the correct new remainder.
    always_comb begin
        shl           = {rem_q, quo_q[WIDTH-1]};
        {borrow, sub} = {1'b0, shl[WIDTH-1:0]} - {1'b0, dvs_q};
        take          = shl[WIDTH] | ~borrow;
        rem_nx        = take ? sub : shl[WIDTH-1:0];
        quo_nx        = {quo_q[WIDTH-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    cnt_d = '0;
                    rem_d = '0;
                    if (divisor == '0) begin
                        state_d = S_ZERO;
                        quo_d   = dividend;
                    end else begin
                        state_d = S_CALC;
                        quo_d   = magnitude(dividend, is_signed);
                        dvs_d   = magnitude(divisor, is_signed);
                        qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_d  = is_signed & dividend[WIDTH-1];
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_DONE;
                    res_d   = {cond_neg(rem_nx, rneg_q), cond_neg(quo_nx, qneg_q)};
                end
            end
            S_ZERO: begin
                state_d = S_DONE;
                res_d   = {quo_q, {WIDTH{1'b1}}};
            end
            default: state_d = S_IDLE;
        endcase
        if (annul) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
        busy_d = (state_d == S_CALC) || (state_d == S_ZERO);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotients/remainders, latency, annul and reset cases.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           is_signed;
    logic           annul;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .annul     (annul),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at the next edge and watch 40 cycles; glitch_at pulses a stray start.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input int exp_busy, input int glitch_at);
        int done_at = 0;
        int busy_n  = 0;
        int done_n  = 0;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = j;
                    chk({tag, "/result"}, result, exp_res);
                end
            end
            start = (j == glitch_at);
            if (j == glitch_at) begin
                dividend = 32'd50;
                divisor  = 32'd5;
            end
        end
        start = 1'b0;
        chk({tag, "/latency"}, 64'(done_at), 64'(exp_lat));
        chk({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        chk({tag, "/done_pulses"}, 64'(done_n), 64'd1);
    endtask

    task automatic idle_watch(input string tag, input logic [63:0] exp_res);
        int done_n = 0;
        int busy_n = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) busy_n++;
        end
        chk({tag, "/no_done"}, 64'(done_n), 64'd0);
        chk({tag, "/no_busy"}, 64'(busy_n), 64'd0);
        chk({tag, "/result_held"}, result, exp_res);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        annul     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/done", 64'(done), 64'd0);
        chk("reset/result", result, 64'd0);
        rst = 1'b0;

        run_div("divu_100_7",   1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33, 32, 0);
        run_div("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 32, 0);
        run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 32, 0);
        run_div("div_m7_m2",    1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, 32, 0);
        run_div("div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33, 32, 0);
        run_div("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33, 32, 0);
        run_div("divu_big_dvs", 1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33, 32, 0);
        run_div("divu_max_m1",  1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 64'h00000001_00000001, 33, 32, 0);
        run_div("divu_5_0",     1'b0, 32'd5,          32'd0,        64'h00000005_FFFFFFFF, 2,  1,  0);

        // Annul mid-calculation leaves the previous result in place.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("annul/busy_drop", 64'(busy), 64'd0);
        idle_watch("annul", 64'h00000005_FFFFFFFF);
        run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 33, 32, 0);

        // Annul wins over a same-cycle start.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        idle_watch("annul_vs_start", 64'h00000001_00000002);

        run_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 2, 1, 0);

        // Stray starts while busy and while in DONE must be ignored.
        run_div("start_in_calc", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 32, 5);
        run_div("start_in_done", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 32, 33);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst/busy", 64'(busy), 64'd0);
        chk("async_rst/done", 64'(done), 64'd0);
        chk("async_rst/result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_watch("after_rst", 64'd0);
        run_div("after_rst_div", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
